// File: rtl/device_console_pkg.sv
// Shared console definitions: register map, STATUS bit layout and transmitter states.
package device_console_pkg;

    localparam logic [9:0] AddrTxData  = 10'h000;
    localparam logic [9:0] AddrStatus  = 10'h001;
    localparam logic [9:0] AddrCoreId  = 10'h002;
    localparam logic [9:0] AddrCycleLo = 10'h003;
    localparam logic [9:0] AddrCycleHi = 10'h004;

    localparam int unsigned StatusFullBit  = 0;
    localparam int unsigned StatusEmptyBit = 1;
    localparam int unsigned StatusOvfBit   = 2;
    localparam int unsigned StatusBusyBit  = 3;
    localparam int unsigned StatusCountLsb = 4;
    localparam int unsigned StatusCountW   = 7;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    function automatic logic [15:0] pack_status(input logic full, input logic empty,
                                                input logic ovf, input logic busy,
                                                input logic [StatusCountW-1:0] count);
        logic [15:0] s;
        s = '0;
        s[StatusFullBit]  = full;
        s[StatusEmptyBit] = empty;
        s[StatusOvfBit]   = ovf;
        s[StatusBusyBit]  = busy;
        s[StatusCountLsb +: StatusCountW] = count;
        return s;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Byte FIFO for the console transmitter; a push while full is dropped even if a pop coincides.
module console_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [7:0]      mem [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/device_console.sv
// Memory-mapped UART console with a TX FIFO; defining CONSOLE_CYCLE_COUNTER_EN adds a
// 32-bit free-running cycle counter readable through CYCLE_LO/CYCLE_HI.
module device_console
    import device_console_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned CLK_DIVISOR = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  device_core_id,
    input  logic        device_write_en,
    input  logic        device_read_en,
    input  logic [9:0]  device_addr,
    input  logic [15:0] device_data_out,
    output logic [15:0] device_data_in,
    output logic        uart_tx
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned DivW = (CLK_DIVISOR > 1) ? $clog2(CLK_DIVISOR) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIVISOR - 1);

    logic            tx_wr, status_wr;
    logic            fifo_full, fifo_empty, fifo_pop;
    logic [7:0]      fifo_rdata;
    logic [CntW-1:0] fifo_count;
    logic            overflow_q, overflow_d;
    logic [15:0]     rdata, data_in_q;
    logic            unused_data_hi;

    tx_state_e       state_q, state_d;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            bit_last;

    assign tx_wr          = device_write_en && (device_addr == AddrTxData);
    assign status_wr      = device_write_en && (device_addr == AddrStatus);
    assign unused_data_hi = ^device_data_out[15:8];

    console_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_wr),
        .wdata (device_data_out[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A dropped write and a STATUS clear on the same edge leave the flag set.
    assign overflow_d = (tx_wr && fifo_full) || (overflow_q && !status_wr);

    assign bit_last = (div_cnt_q == DivLast);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        tx_d      = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_rdata;
                    div_cnt_d = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                tx_d = 1'b0;
                if (bit_last) begin
                    div_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else begin
                    div_cnt_d = div_cnt_q + DivW'(1);
                end
            end
            StData: begin
                tx_d = shift_q[0];
                if (bit_last) begin
                    div_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DivW'(1);
                end
            end
            StStop: begin
                if (bit_last) begin
                    div_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    div_cnt_d = div_cnt_q + DivW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // uart_tx is registered from the state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            div_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign uart_tx = tx_q;

`ifdef CONSOLE_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;
    logic [15:0] cycle_hi_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q    <= '0;
            cycle_hi_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (device_read_en && (device_addr == AddrCycleLo)) begin
                cycle_hi_q <= cycle_q[31:16];
            end
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (device_addr)
            AddrStatus:  rdata = pack_status(fifo_full, fifo_empty, overflow_q,
                                             (state_q != StIdle),
                                             StatusCountW'(fifo_count));
            AddrCoreId:  rdata = {12'h000, device_core_id};
`ifdef CONSOLE_CYCLE_COUNTER_EN
            AddrCycleLo: rdata = cycle_q[15:0];
            AddrCycleHi: rdata = cycle_hi_q;
`endif
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_in_q <= '0;
        end else if (device_read_en) begin
            data_in_q <= rdata;
        end
    end

    assign device_data_in = data_in_q;

endmodule

// File: doc/device_console.md
DEVICE_CONSOLE -- requirements
Module: device_console

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: number of TX byte entries, power of two, 2..64.
REQ-002 SHALL have parameter CLK_DIVISOR, default 16: clock cycles per serial bit, at least 2.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port device_core_id  in  4  binary ID of the core that owns the current access.
REQ-006 SHALL have port device_write_en  in  1  register write strobe, one cycle per access.
REQ-007 SHALL have port device_read_en  in  1  register read strobe, one cycle per access.
REQ-008 SHALL have port device_addr  in  10  register word address.
REQ-009 SHALL have port device_data_out  in  16  write data from the cluster.
REQ-010 SHALL have port device_data_in  out  16  read data to the cluster.
REQ-011 SHALL have port uart_tx  out  1  serial console line, idle high.

Function
REQ-012 SHALL decode the register map: 0x000 TX_DATA (W), 0x001 STATUS (R/W), 0x002 CORE_ID (R), 0x003 CYCLE_LO (R), 0x004 CYCLE_HI (R); all other reads return 0x0000 and all other writes are ignored.
REQ-013 SHALL register device_data_in: the value is valid the cycle after device_read_en and is held until the next read.
REQ-014 SHALL push device_data_out[7:0] into the TX FIFO on a TX_DATA write and ignore bits [15:8].
REQ-015 SHALL drop a TX_DATA write when the FIFO is full at that edge, even if a pop occurs on the same edge, and SHALL set the sticky overflow flag.
REQ-016 SHALL allow a push and a pop on the same edge when the FIFO is not full, leaving the count unchanged.
REQ-017 SHALL return on a STATUS read: bit0 full, bit1 empty, bit2 overflow, bit3 transmitter busy, bits[10:4] FIFO count, all other bits zero.
REQ-018 SHALL clear overflow on any write to STATUS; if an overflow event occurs on the same edge, set wins.
REQ-019 SHALL return {12'h000, device_core_id} on a CORE_ID read, sampled in the read cycle.
REQ-020 SHALL implement the transmitter FSM with states IDLE, START, DATA, STOP.
REQ-021 IDLE SHALL pop the FIFO head into the shift register on the edge where the FIFO is non-empty, then enter START.
REQ-022 START SHALL drive uart_tx low for CLK_DIVISOR cycles, then enter DATA.
REQ-023 DATA SHALL send 8 bits LSB first, CLK_DIVISOR cycles each, then enter STOP.
REQ-024 STOP SHALL drive uart_tx high for CLK_DIVISOR cycles, then enter IDLE.
REQ-025 SHALL make frames occupy 10*CLK_DIVISOR cycles, with exactly one IDLE cycle between back-to-back frames.
REQ-026 SHALL drive the start bit low beginning on the second edge after the edge that samples a TX_DATA write into an empty, idle console.
REQ-027 SHALL perform both the read and the write when device_read_en and device_write_en are asserted in the same cycle; the read returns the pre-write state.

Reset
REQ-028 SHALL, while reset=0, force uart_tx=1, device_data_in=0x0000, FSM=IDLE, FIFO empty, overflow=0, cycle counter=0 and HI snapshot=0, regardless of clk.
REQ-029 SHALL, when reset is asserted mid-frame, abort the frame and discard all queued bytes.

Configuration
REQ-030 SHALL, when CONSOLE_CYCLE_COUNTER_EN is defined, keep a 32-bit counter that increments every cycle and wraps to 0; a CYCLE_LO read returns bits [15:0] and latches bits [31:16] into a snapshot that a CYCLE_HI read returns.
REQ-031 SHALL, when CONSOLE_CYCLE_COUNTER_EN is undefined, instantiate no counter or snapshot logic, and CYCLE_LO/CYCLE_HI SHALL read 0x0000.

Structure
REQ-032 SHALL place the register address constants and STATUS bit positions in the shared cluster definitions package.
REQ-033 SHALL implement the FIFO as sub-module console_fifo (parameter DEPTH; push, pop, full, empty, count outputs).

Verification
REQ-034 Reset, then STATUS read -> uart_tx=1, device_data_in=0x0002 the cycle after the read.
REQ-035 CLK_DIVISOR=16, write 0x0155 to 0x000 -> uart_tx low 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high 16 cycles.
REQ-036 FIFO_DEPTH=8, ten TX_DATA writes on consecutive cycles into an idle console -> STATUS bit2=1 and bit0=1; exactly 9 frames observed, 10th byte absent; a STATUS write then reads bit2=0.
REQ-037 CORE_ID read with device_core_id=4'hA -> device_data_in=0x000A the next cycle; read of 0x3FF -> 0x0000.
REQ-038 With CONSOLE_CYCLE_COUNTER_EN, CYCLE_LO read then CYCLE_HI read with counter preset near 0x0000FFFF -> {HI,LO} is consistent across the carry; without the macro both read 0x0000.
REQ-039 reset=0 asserted during DATA of a frame with 3 bytes queued -> uart_tx=1 immediately; after release STATUS=0x0002 and no further frames are sent.
